alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU (in_a, in_b, alu_select → result) between two requesters: the execute stage (req0) and the branch/address unit (req1).
- Arbitrates round-robin and registers the selected operands onto the ALU inputs.
- Captures the ALU result and returns it tagged with the requester ID over a valid/ready response channel.
- Sits between the decode/issue logic and the ALU instance.

Parameters:
- WIDTH, 32, operand and result width.
- SEL_W, 4, ALU select width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_sel  in  SEL_W  requester 0 ALU select
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  WIDTH  requester 1 operand A
- req1_b  in  WIDTH  requester 1 operand B
- req1_sel  in  SEL_W  requester 1 ALU select
- alu_a  out  WIDTH  to ALU in_a (registered)
- alu_b  out  WIDTH  to ALU in_b (registered)
- alu_sel  out  SEL_W  to ALU alu_select (registered)
- alu_result  in  WIDTH  from ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  0 = req0, 1 = req1
- rsp_data  out  WIDTH  captured ALU result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; alu_a=0, alu_b=0, alu_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0, last_grant=1. req*_ready=0 while in reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic: only req0_valid → grant 0. Only req1_valid → grant 1. Both valid → grant the one not equal to last_grant. Neither valid → stay IDLE.
  - req0_ready / req1_ready are combinational: high only in IDLE, only for the granted requester, and only while that requester's valid is high. At most one ready is high in any cycle.
  - On grant at the clock edge: latch the granted a/b/sel into alu_a/alu_b/alu_sel; latch the grant into an internal id register; last_grant ← grant; go to EXEC.
- EXEC (exactly one cycle):
  - ALU inputs are stable from the registers.
  - At the clock edge: rsp_data ← alu_result; rsp_id ← id; rsp_valid ← 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On rsp_valid & rsp_ready at the clock edge: rsp_valid ← 0; go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Timing:
  - Latency from accept edge to rsp_valid high is 2 clocks.
  - Minimum issue interval is 3 clocks (accept, EXEC, RESP with rsp_ready=1).
- ALU outputs hold their last values outside EXEC; they are not cleared.
- Requester inputs are sampled only on the accept edge. Changes to a/b/sel after accept have no effect.
- Requester valid deasserted before a grant is legal; no state changes.
- Backpressure: rsp_ready low holds RESP indefinitely. Both requesters see ready=0 during this time and busy=1.
- Reset mid-operation (EXEC or RESP): in-flight op discarded, all outputs to reset values, last_grant=1, so req0 wins the first contention after reset.
- No arithmetic in the block. Result width equals WIDTH, passed through unmodified.

Test Plan:
- Bench stubs alu_result = alu_a + alu_b (WIDTH-bit wrap).
- Single request: reset, then req0 a=32'h0000_0005, b=32'h0000_0003, sel=4'h0 → req0_ready high 1 cycle; alu_a=5, alu_b=3 next cycle; rsp_valid high 2 clocks after accept with rsp_id=0, rsp_data=32'h0000_0008.
- Contention with round-robin: req0 and req1 both valid continuously (req1 a=32'hFFFF_FFFF, b=32'h1), rsp_ready=1 → grant order 0,1,0,1. req1 responses carry rsp_id=1, rsp_data=32'h0000_0000.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_data/rsp_id stable, busy=1, both readies 0. Raise rsp_ready → rsp_valid drops next edge and the state returns to IDLE.
- Sole requester after a grant to it: only req1 valid for three ops → all three granted to req1 (no idle gaps beyond the 3-cycle issue interval). last_grant does not block a lone requester.
- Operand change after accept: change req0_a to 32'hDEAD_BEEF one cycle after accept → rsp_data reflects the original operands.
- Async reset in RESP: assert rst_n=0 mid-cycle while rsp_valid=1 → rsp_valid, rsp_data and alu_* go to 0 immediately. After release, with both valid, req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters, result returned with requester id.
// Latency: 2 clocks from accept edge to rsp_valid (operands registered, then result captured); one op in flight.
// Backpressure: rsp_ready low holds the response indefinitely; both requesters see ready=0 until it drains.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   id_q;        // requester that owns the op in flight
    logic   last_grant;  // most recent winner; loses the next tie
    logic   grant;
    logic   any_vld;

    // Pick a winner: a lone requester always wins, a tie goes to whoever did not win last.
    always_comb begin
        any_vld = req0_valid | req1_valid;
        grant   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    // Ready only while idle and out of reset, and only towards the current winner.
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
    assign busy       = (state != IDLE);

    // Operand capture, result capture and response handshake sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        alu_a      <= grant ? req1_a   : req0_a;
                        alu_b      <= grant ? req1_b   : req0_b;
                        alu_sel    <= grant ? req1_sel : req0_sel;
                        id_q       <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Return to IDLE only; a new grant waits for the following cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: randomized and directed checking of alu_arbiter against a cycle-level reference model.
// Latency: model expects operands on the ALU one clock after accept and the response two clocks after.
// Backpressure: rsp_ready is toggled at random and held low for long stretches.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [SEL_W-1:0] req0_sel, req1_sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic [SEL_W-1:0] alu_sel;
    logic             rsp_valid, rsp_ready, rsp_id, busy;

    always #5 clk = ~clk;

    // ALU stub: plain addition with natural wrap.
    assign alu_result = alu_a + alu_b;

    alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t sbq[$];   // expected responses, oldest first
    int   glog[$];  // grants observed on the DUT ready/valid pairs
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: one op outstanding at most, accepted at cycle t_acc.
    bit               pending;
    int               t_acc;
    bit               m_last;
    logic [WIDTH-1:0] m_alu_a, m_alu_b;
    logic [SEL_W-1:0] m_alu_sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pending   = 1'b0;
        t_acc     = 0;
        m_last    = 1'b1;
        m_alu_a   = '0;
        m_alu_b   = '0;
        m_alu_sel = '0;
        sbq.delete();
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
    task automatic step();
        bit idle, g, rv;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_req0_ready", 64'(req0_ready), 64'(0));
            chk("rst_req1_ready", 64'(req1_ready), 64'(0));
            chk("rst_busy",       64'(busy),       64'(0));
            chk("rst_rsp_valid",  64'(rsp_valid),  64'(0));
        end else begin
            if (req0_ready && req0_valid) glog.push_back(0);
            if (req1_ready && req1_valid) glog.push_back(1);
            idle = !pending;
            g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            rv   = pending && (cyc >= t_acc + 2);
            chk("req0_ready", 64'(req0_ready), 64'(idle && req0_valid && !g));
            chk("req1_ready", 64'(req1_ready), 64'(idle && req1_valid && g));
            chk("busy",       64'(busy),       64'(pending));
            chk("rsp_valid",  64'(rsp_valid),  64'(rv));
            chk("alu_a",      64'(alu_a),      64'(m_alu_a));
            chk("alu_b",      64'(alu_b),      64'(m_alu_b));
            chk("alu_sel",    64'(alu_sel),    64'(m_alu_sel));
            if (idle && (req0_valid || req1_valid)) begin
                pending   = 1'b1;
                t_acc     = cyc;
                m_last    = g;
                m_alu_a   = g ? req1_a   : req0_a;
                m_alu_b   = g ? req1_b   : req0_b;
                m_alu_sel = g ? req1_sel : req0_sel;
                sbq.push_back({g, m_alu_a + m_alu_b});
            end else if (rv && rsp_ready) begin
                pending = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Response monitor: every presented response must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%0h expected no response (cycle %0d)", rsp_id, rsp_data, cyc);
            end else begin
                chk("rsp_id",   64'(rsp_id),   64'(sbq[0].id));
                chk("rsp_data", 64'(rsp_data), 64'(sbq[0].data));
                if (rsp_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp_valid(input string name);
        for (int i = 0; i < 10 && !rsp_valid; i++) step();
        chk(name, 64'(rsp_valid), 64'(1));
    endtask

    initial begin
        idle_inputs();
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        // Ready must stay low in reset even with a request present.
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        do_reset();

        // Single request from requester 0: 5 + 3.
        req0_valid = 1'b1; req0_a = 32'h0000_0005; req0_b = 32'h0000_0003; req0_sel = 4'h0;
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Continuous contention after reset: grants alternate starting with requester 0.
        do_reset();
        glog.delete();
        req0_valid = 1'b1; req0_a = 32'h0000_0005; req0_b = 32'h0000_0003; req0_sel = 4'h2;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0001; req1_sel = 4'h7;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("rr_grant_count", 64'(glog.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            chk("rr_grant_order", 64'((i < glog.size()) ? glog[i] : 9), 64'(i % 2));
        drain();

        // Backpressure: response held five extra cycles while both requesters wait.
        req0_valid = 1'b1; req0_a = 32'h0000_1000; req0_b = 32'h0000_0234; req0_sel = 4'h3;
        rsp_ready  = 1'b0;
        step();
        req1_valid = 1'b1; req1_a = 32'h0000_0011; req1_b = 32'h0000_0022;
        wait_rsp_valid("bp_rsp_valid_timeout");
        for (int i = 0; i < 5; i++) step();
        rsp_ready = 1'b1;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Lone requester 1 issues back to back at the minimum interval.
        glog.delete();
        req1_valid = 1'b1; req1_a = 32'h0000_0100; req1_b = 32'h0000_0001; req1_sel = 4'h1;
        for (int i = 0; i < 9; i++) step();
        req1_valid = 1'b0;
        chk("lone_req1_grants", 64'(glog.size()), 64'(3));
        for (int i = 0; i < 3; i++)
            chk("lone_req1_id", 64'((i < glog.size()) ? glog[i] : 9), 64'(1));
        drain();

        // Operand change after accept must not leak into the result.
        req0_valid = 1'b1; req0_a = 32'h0000_0040; req0_b = 32'h0000_0002;
        step();
        req0_valid = 1'b0;
        req0_a     = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) step();
        drain();

        // Asynchronous reset while a response is held.
        req0_valid = 1'b1; req0_a = 32'h1234_0000; req0_b = 32'h0000_5678; req0_sel = 4'hA;
        rsp_ready  = 1'b0;
        step();
        req0_valid = 1'b0;
        wait_rsp_valid("rst_rsp_valid_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("arst_rsp_data",  64'(rsp_data),  64'(0));
        chk("arst_rsp_id",    64'(rsp_id),    64'(0));
        chk("arst_alu_a",     64'(alu_a),     64'(0));
        chk("arst_alu_b",     64'(alu_b),     64'(0));
        chk("arst_alu_sel",   64'(alu_sel),   64'(0));
        chk("arst_busy",      64'(busy),      64'(0));
        model_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        step();
        step();
        glog.delete();
        rst_n = 1'b1;
        step();
        chk("post_reset_first_grant", 64'((glog.size() > 0) ? glog[0] : 9), 64'(0));
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a     = $urandom; req0_b = $urandom; req0_sel = 4'($urandom_range(0, 15));
            req1_a     = $urandom; req1_b = $urandom; req1_sel = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
